had_mult_fold: RTL and testbench
================================

// Module: had_mult_fold
// PURPOSE
//  Parametrised, time-multiplexed Hadamard (element-wise) signed fixed-point multiplier.
//  Accepts one vector pair x,y of N_LANES signed WIDTH-bit lanes (Q(WIDTH-FRAC).FRAC).
//  Multiplies P lanes per cycle and returns a fixed-point product vector z through a valid/ready output.
//  Sits in the NN datapath between the activation/weight buffers and the layer accumulators.
// PARAMETERS
//  N_LANES   32  lanes per vector
//  WIDTH     32  bits per lane, signed two's complement
//  FRAC      24  fractional bits; legal range 0..WIDTH-1
//  P         8   multipliers instantiated; must divide N_LANES; B = N_LANES/P beats per vector
//  SATURATE  1   1 = clamp out-of-range results; 0 = wrap (keep the low WIDTH bits)
//  ROUND     1   1 = round half up (add 2^(FRAC-1) before shift); 0 = truncate; ignored when FRAC=0
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               synchronous reset, active low
//  in_valid   in   1               x/y valid
//  in_ready   out  1               block can accept x/y
//  x          in   N_LANES*WIDTH   lane 0 in MSBs, i.e. {lane0,...,laneN-1}
//  y          in   N_LANES*WIDTH   same packing as x
//  out_valid  out  1               z/ovf valid
//  out_ready  in   1               consumer accepts z
//  z          out  N_LANES*WIDTH   product vector, same packing as x
//  ovf        out  1               1 if any lane of this vector overflowed WIDTH
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state IDLE, beat counter 0, x/y/z registers 0, ovf 0, out_valid 0.
//   in_ready reads 1 in the cycle after reset.
//  FSM states:
//   IDLE: in_ready=1, out_valid=0. in_valid=1 at an edge captures x and y, clears ovf and beat, and moves to BUSY.
//   BUSY: in_ready=0, out_valid=0. Each edge computes lanes beat*P .. beat*P+P-1 into z and increments beat.
//         The edge that processes beat B-1 moves to DONE.
//   DONE: out_valid=1, in_ready=0. z and ovf are held stable. out_ready=1 at an edge moves to IDLE.
//  Latency: out_valid rises B edges after the accepting edge. With P=N_LANES, DONE follows one edge after accept.
//  Throughput: at most one vector per B+2 cycles. No overlap: in_valid is ignored outside IDLE.
//  z content: guaranteed only while out_valid=1. Lanes may change during BUSY.
//  Per-lane arithmetic:
//   p = x*y, full 2*WIDTH-bit signed product.
//   If ROUND and FRAC>0, p += 2^(FRAC-1).
//   r = p >>> FRAC (arithmetic shift).
//   If r lies in [-2^(WIDTH-1), 2^(WIDTH-1)-1], the lane result is r.
//   Otherwise ovf is set (sticky for this vector) and the lane result is:
//     SATURATE=1: 2^(WIDTH-1)-1 when r>0, -2^(WIDTH-1) when r<0.
//     SATURATE=0: r[WIDTH-1:0].
//  Reset mid-operation (BUSY or DONE): the vector is aborted with no partial out_valid and full reset values apply.
//  out_ready held high in IDLE/BUSY has no effect.
//  Illegal parameters (P not dividing N_LANES, FRAC>=WIDTH) must fail at elaboration.
// TESTING  (defaults unless noted; N=32, P=8, B=4; all lanes equal unless noted)
//  1. x=0x01800000 (1.5), y=0x02000000 (2.0) -> z lanes 0x03000000, ovf=0.
//     out_valid rises exactly 4 edges after accept.
//  2. Sign: x=0xFF000000 (-1.0), y=0x00800000 (0.5) -> 0xFF800000.
//     Mixed lanes: lane k = k * lane-0 values, checking the lane-0-at-MSB ordering.
//  3. Overflow: x=y=0x64000000 (100.0) -> SATURATE=1: 0x7FFFFFFF, ovf=1.
//     SATURATE=0: 0x10000000, ovf=1. Next in-range vector returns ovf=0.
//  4. Rounding: x=0x00000001, y=0x00800000 -> ROUND=1: 0x00000001; ROUND=0: 0x00000000.
//     Also check x=-1 LSB (0xFFFFFFFF): ROUND=1 gives 0x00000000, ROUND=0 gives 0xFFFFFFFF.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new data.
//     -> out_valid stays 1, z and ovf stable, in_ready=0, new data not captured.
//     On release, IDLE is entered and the next vector is accepted.
//  6. Drive rst_n=0 during BUSY beat 2 -> next cycle out_valid=0, in_ready=1, z=0.
//     The following vector from test 1 completes correctly. Repeat with P=32 (B=1) and P=1 (B=32).

Source files
------------

// File: rtl/had_mult_fold.sv
`default_nettype none
// ============================================================================
//  Module      : had_mult_fold
//  Description : Time-multiplexed Hadamard (element-wise) signed fixed-point
//                multiplier; P lanes per cycle, valid/ready handshaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module had_mult_fold #(
  parameter int N_LANES  = 32,
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int P        = 8,
  parameter int SATURATE = 1,
  parameter int ROUND    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_LANES*WIDTH-1:0]   x,
  input  logic [N_LANES*WIDTH-1:0]   y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LANES*WIDTH-1:0]   z,
  output logic                       ovf
);

  localparam int c_B  = N_LANES / P;
  localparam int c_BW = (c_B > 1) ? $clog2(c_B) : 1;
  localparam int c_LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int c_PW = 2 * WIDTH;
  localparam logic signed [c_PW-1:0] c_RND =
    ((ROUND != 0) && (FRAC > 0)) ? (c_PW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic [WIDTH-1:0] c_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if ((P < 1) || (N_LANES % P != 0) || (FRAC < 0) || (FRAC >= WIDTH)) begin : g_param_check
      $error("had_mult_fold: illegal parameters (P must divide N_LANES, 0 <= FRAC < WIDTH)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [c_BW-1:0]          r_beat;
  logic signed [WIDTH-1:0]  r_x [N_LANES];
  logic signed [WIDTH-1:0]  r_y [N_LANES];
  logic [WIDTH-1:0]         r_z [N_LANES];
  logic                     r_ovf;
  logic                     r_in_ready;
  logic                     r_out_valid;

  logic signed [WIDTH-1:0]  w_xin [N_LANES];
  logic signed [WIDTH-1:0]  w_yin [N_LANES];
  logic [c_LW-1:0]          w_lane [P];
  logic [WIDTH-1:0]         w_res [P];
  logic [P-1:0]             w_lane_ovf;

  // Lane 0 occupies the MSBs of the packed vectors.
  generate
    for (genvar i = 0; i < N_LANES; i++) begin : g_pack
      assign w_xin[i] = x[(N_LANES-1-i)*WIDTH +: WIDTH];
      assign w_yin[i] = y[(N_LANES-1-i)*WIDTH +: WIDTH];
      assign z[(N_LANES-1-i)*WIDTH +: WIDTH] = r_z[i];
    end
  endgenerate

  generate
    for (genvar j = 0; j < P; j++) begin : g_lane
      logic signed [WIDTH-1:0] w_xa;
      logic signed [WIDTH-1:0] w_ya;
      logic signed [c_PW-1:0]  w_xe;
      logic signed [c_PW-1:0]  w_ye;
      logic signed [c_PW-1:0]  w_prod;
      logic signed [c_PW-1:0]  w_shift;
      logic                    w_fits;

      assign w_lane[j] = c_LW'(32'(r_beat) * P + j);
      assign w_xa      = r_x[w_lane[j]];
      assign w_ya      = r_y[w_lane[j]];
      assign w_xe      = {{WIDTH{w_xa[WIDTH-1]}}, w_xa};
      assign w_ye      = {{WIDTH{w_ya[WIDTH-1]}}, w_ya};
      assign w_prod    = (w_xe * w_ye) + c_RND;
      assign w_shift   = w_prod >>> FRAC;
      // Result fits when every bit above the target sign bit copies it.
      assign w_fits    = (&w_shift[c_PW-1:WIDTH-1]) | ~(|w_shift[c_PW-1:WIDTH-1]);
      assign w_lane_ovf[j] = ~w_fits;

      always_comb begin
        w_res[j] = w_shift[WIDTH-1:0];
        if (!w_fits && (SATURATE != 0)) begin
          w_res[j] = w_shift[c_PW-1] ? c_MIN : c_MAX;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_z[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_LANES; i++) begin
              r_x[i] <= w_xin[i];
              r_y[i] <= w_yin[i];
            end
            r_ovf      <= 1'b0;
            r_beat     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          for (int j = 0; j < P; j++) begin
            r_z[w_lane[j]] <= w_res[j];
          end
          if (|w_lane_ovf) begin
            r_ovf <= 1'b1;
          end
          if (r_beat == c_BW'(c_B - 1)) begin
            r_beat      <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_beat <= r_beat + c_BW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_had_mult_fold.sv
`default_nettype none
// ============================================================================
//  Module      : tb_had_mult_fold
//  Description : Self-checking bench; four parameter variants driven in lockstep
//                and compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_had_mult_fold;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int NW = N * W;
  localparam int NDUT = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [NW-1:0] x;
  logic [NW-1:0] y;
  wire  [NDUT-1:0] ir;
  wire  [NDUT-1:0] ov;
  wire  [NDUT-1:0] of;
  wire  [NW-1:0]   zo [NDUT];

  int checks = 0;
  int errors = 0;

  // Variant 0: defaults; 1: wrap + truncate; 2: P=32; 3: P=1.
  had_mult_fold #(.P(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .x(x), .y(y),
    .out_valid(ov[0]), .out_ready(out_ready), .z(zo[0]), .ovf(of[0]));
  had_mult_fold #(.P(8), .SATURATE(0), .ROUND(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .x(x), .y(y),
    .out_valid(ov[1]), .out_ready(out_ready), .z(zo[1]), .ovf(of[1]));
  had_mult_fold #(.P(32)) u_p32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .x(x), .y(y),
    .out_valid(ov[2]), .out_ready(out_ready), .z(zo[2]), .ovf(of[2]));
  had_mult_fold #(.P(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .x(x), .y(y),
    .out_valid(ov[3]), .out_ready(out_ready), .z(zo[3]), .ovf(of[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Q8.24 lane product from the arithmetic definition.
  function automatic void lane_model(input logic [31:0] a, input logic [31:0] b,
                                     input bit sat, input bit rnd,
                                     output logic [31:0] r, output bit o);
    longint p, s, hi, lo;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    p  = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + (longint'(1) <<< 23);
    s = p >>> 24;
    o = (s > hi) || (s < lo);
    if (o && sat) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else          r = s[31:0];
  endfunction

  function automatic void vec_model(input logic [NW-1:0] xv, input logic [NW-1:0] yv,
                                    input bit sat, input bit rnd,
                                    output logic [NW-1:0] zv, output bit o);
    logic [31:0] r;
    bit lo;
    o  = 1'b0;
    zv = '0;
    for (int i = 0; i < N; i++) begin
      lane_model(xv[(N-1-i)*W +: W], yv[(N-1-i)*W +: W], sat, rnd, r, lo);
      zv[(N-1-i)*W +: W] = r;
      o = o | lo;
    end
  endfunction

  function automatic logic [NW-1:0] splat(input logic [31:0] v);
    logic [NW-1:0] t;
    for (int i = 0; i < N; i++) t[i*W +: W] = v;
    return t;
  endfunction

  function automatic logic [31:0] rand_lane();
    logic [31:0] tbl [6];
    logic [31:0] v;
    tbl[0] = 32'h7FFF_FFFF; tbl[1] = 32'h8000_0000; tbl[2] = 32'h0;
    tbl[3] = 32'hFFFF_FFFF; tbl[4] = 32'h0100_0000; tbl[5] = 32'hFF00_0000;
    case ($urandom_range(0, 2))
      0:       v = $urandom;
      1: begin
        v = $urandom & 32'h07FF_FFFF;
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = tbl[$urandom_range(0, 5)];
    endcase
    return v;
  endfunction

  task automatic run_vec(input string tag, input logic [NW-1:0] xv, input logic [NW-1:0] yv,
                         input bit hold);
    logic [NW-1:0]   ez [NDUT];
    logic [NDUT-1:0] eo;
    bit              o;
    int              lat [NDUT];
    int              exp_lat [NDUT];
    int              cyc;
    exp_lat[0] = 4; exp_lat[1] = 4; exp_lat[2] = 1; exp_lat[3] = 32;
    for (int d = 0; d < NDUT; d++) begin
      vec_model(xv, yv, d != 1, d != 1, ez[d], o);
      eo[d] = o;
      lat[d] = -1;
    end
    check({tag, ".in_ready_pre"}, NW'(ir), NW'(4'hF));
    x = xv;
    y = yv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0) && cyc < 64) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < NDUT; d++) if (ov[d] && lat[d] < 0) lat[d] = cyc;
    end
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s.latency[%0d]", tag, d), NW'(lat[d]), NW'(exp_lat[d]));
      check($sformatf("%s.z[%0d]", tag, d), zo[d], ez[d]);
    end
    check({tag, ".ovf"}, NW'(of), NW'(eo));
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        x = splat($urandom);
        y = splat($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check($sformatf("%s.hold_valid%0d", tag, c), NW'(ov), NW'(4'hF));
        check($sformatf("%s.hold_ready%0d", tag, c), NW'(ir), NW'(4'h0));
        check($sformatf("%s.hold_ovf%0d", tag, c), NW'(of), NW'(eo));
        for (int d = 0; d < NDUT; d++)
          check($sformatf("%s.hold_z%0d[%0d]", tag, c, d), zo[d], ez[d]);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".release_valid"}, NW'(ov), NW'(4'h0));
    check({tag, ".release_ready"}, NW'(ir), NW'(4'hF));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"}, NW'(ov), NW'(4'h0));
    check({tag, ".in_ready"}, NW'(ir), NW'(4'hF));
    check({tag, ".ovf"}, NW'(of), NW'(4'h0));
    for (int d = 0; d < NDUT; d++) check($sformatf("%s.z[%0d]", tag, d), zo[d], '0);
  endtask

  initial begin
    logic [NW-1:0] xv;
    logic [NW-1:0] yv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_vec("t1_basic", splat(32'h0180_0000), splat(32'h0200_0000), 1'b0);
    run_vec("t2_sign", splat(32'hFF00_0000), splat(32'h0080_0000), 1'b0);
    for (int k = 0; k < N; k++) begin
      xv[(N-1-k)*W +: W] = 32'(k) * 32'hFF00_0000;
      yv[(N-1-k)*W +: W] = 32'(k) * 32'h0080_0000;
    end
    run_vec("t2_mixed", xv, yv, 1'b0);
    run_vec("t3_ovf", splat(32'h6400_0000), splat(32'h6400_0000), 1'b0);
    run_vec("t3_clear", splat(32'h0180_0000), splat(32'h0200_0000), 1'b0);
    run_vec("t4_rnd_pos", splat(32'h0000_0001), splat(32'h0080_0000), 1'b0);
    run_vec("t4_rnd_neg", splat(32'hFFFF_FFFF), splat(32'h0080_0000), 1'b0);
    run_vec("t5_hold", splat(32'hFF00_0000), splat(32'h0080_0000), 1'b1);
    run_vec("t5_next", splat(32'h0180_0000), splat(32'h0200_0000), 1'b0);

    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < N; k++) begin
        xv[k*W +: W] = rand_lane();
        yv[k*W +: W] = rand_lane();
      end
      run_vec($sformatf("rand%0d", v), xv, yv, 1'b0);
    end

    // Abort while the P=8 variants are about to process beat 2.
    x = splat(32'h6400_0000);
    y = splat(32'h6400_0000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("t6_abort");
    run_vec("t6_after", splat(32'h0180_0000), splat(32'h0200_0000), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
